// File: rtl/output_event_streamer_if.sv
// Event stream interface: valid/ready handshake carrying index, value and timestamp.
interface output_event_streamer_if #(
    parameter int unsigned IDX_W = 5,
    parameter int unsigned TS_W  = 16
);
    logic             ev_valid;
    logic             ev_ready;
    logic [IDX_W-1:0] ev_index;
    logic             ev_value;
    logic [TS_W-1:0]  ev_time;

    modport master (output ev_valid, ev_index, ev_value, ev_time, input ev_ready);
    modport slave  (input ev_valid, ev_index, ev_value, ev_time, output ev_ready);
endinterface

// File: rtl/output_event_streamer.sv
// Per-bit change detector on out_buf feeding a show-ahead event FIFO.
// Optional timestamping is enabled by defining OUTPUT_EVENT_TS_EN.
module output_event_streamer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned IDX_W      = 5,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TS_W       = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            out_buf,
    input  logic                        snap_req,
    output_event_streamer_if.master     ev,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        coalesced,
    input  logic                        clr_flags
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] prev_buf;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] grant_mask;
    logic [IDX_W-1:0] grant_idx;
    logic             grant;
    logic             pop;
    logic             full;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [IDX_W-1:0] idx_mem [FIFO_DEPTH];
    logic             val_mem [FIFO_DEPTH];

    // Lowest set pending bit wins the single grant slot.
    always_comb begin
        grant_idx = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (pending[i]) grant_idx = IDX_W'(i);
        end
    end

    assign diff       = out_buf ^ prev_buf;
    assign full       = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign pop        = ev.ev_valid & ev.ev_ready;
    assign grant      = (|pending) & (~full | pop);
    assign grant_mask = grant ? (WIDTH'(1) << grant_idx) : '0;

    assign ev.ev_valid = (fifo_level != '0);
    assign ev.ev_index = ev.ev_valid ? idx_mem[rd_ptr] : '0;
    assign ev.ev_value = ev.ev_valid ? val_mem[rd_ptr] : 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_buf   <= '0;
            pending    <= '0;
            coalesced  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            prev_buf <= out_buf;
            pending  <= (pending & ~grant_mask) | diff | {WIDTH{snap_req}};
            // A re-change on a still-pending bit folds into the queued request.
            if (|(pending & ~grant_mask & diff)) coalesced <= 1'b1;
            else if (clr_flags)                  coalesced <= 1'b0;
            if (grant) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            case ({grant, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // Value is taken from the most recent sample, not from detection time.
    always_ff @(posedge clk) begin
        if (grant) begin
            idx_mem[wr_ptr] <= grant_idx;
            val_mem[wr_ptr] <= prev_buf[grant_idx];
        end
    end

`ifdef OUTPUT_EVENT_TS_EN
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] ts_mem [FIFO_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts <= '0;
        else        ts <= ts + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (grant) ts_mem[wr_ptr] <= ts;
    end

    assign ev.ev_time = ev.ev_valid ? ts_mem[rd_ptr] : '0;
`else
    assign ev.ev_time = TS_W'(0);
`endif

endmodule

// File: tb/tb_output_event_streamer.sv
// Bench for output_event_streamer: constant vector table, directed corner cases,
// and random traffic checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_output_event_streamer;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TS_W  = 16;
    localparam int unsigned LVL_W = 4;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic [WIDTH-1:0] out_buf   = '0;
    logic             snap_req  = 1'b0;
    logic             clr_flags = 1'b0;
    logic [LVL_W-1:0] fifo_level;
    logic             coalesced;

    output_event_streamer_if #(.IDX_W(IDX_W), .TS_W(TS_W)) ev ();

    output_event_streamer #(
        .WIDTH(WIDTH), .IDX_W(IDX_W), .FIFO_DEPTH(DEPTH), .TS_W(TS_W)
    ) dut (
        .clk(clk), .reset(reset), .out_buf(out_buf), .snap_req(snap_req),
        .ev(ev), .fifo_level(fifo_level), .coalesced(coalesced), .clr_flags(clr_flags)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: event queue plus pending set
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             val;
        logic [TS_W-1:0]  ts;
    } ent_t;

    ent_t             mq[$];
    logic [WIDTH-1:0] m_prev, m_pend;
    logic             m_coal;
    logic [TS_W-1:0]  m_ts;

    function automatic void model_reset();
        mq.delete();
        m_prev = '0; m_pend = '0; m_coal = 1'b0; m_ts = '0;
    endfunction

    function automatic void model_step();
        bit               popv = (mq.size() != 0) && ev.ev_ready;
        int               g    = -1;
        logic [WIDTH-1:0] gm   = '0;
        logic [WIDTH-1:0] d;
        ent_t             e;
        for (int i = 0; i < int'(WIDTH); i++) if (g < 0 && m_pend[i]) g = i;
        if (popv) void'(mq.pop_front());
        if (g >= 0 && (mq.size() < int'(DEPTH))) begin
            e.idx = IDX_W'(g); e.val = m_prev[g]; e.ts = m_ts;
            mq.push_back(e);
            gm = WIDTH'(1) << g;
        end
        d = out_buf ^ m_prev;
        if ((m_pend & ~gm & d) != '0) m_coal = 1'b1;
        else if (clr_flags)           m_coal = 1'b0;
        m_pend = (m_pend & ~gm) | d | (snap_req ? '1 : '0);
        m_prev = out_buf;
        m_ts   = m_ts + TS_W'(1);
    endfunction

    task automatic model_check(string tag);
        bit   v = (mq.size() != 0);
        ent_t h = '0;
        logic [TS_W-1:0] et;
        if (v) h = mq[0];
`ifdef OUTPUT_EVENT_TS_EN
        et = h.ts;
`else
        et = '0;
`endif
        chk({tag, ".valid"}, 32'(ev.ev_valid), 32'(v));
        chk({tag, ".index"}, 32'(ev.ev_index), 32'(h.idx));
        chk({tag, ".value"}, 32'(ev.ev_value), 32'(h.val));
        chk({tag, ".time"},  32'(ev.ev_time),  32'(et));
        chk({tag, ".level"}, 32'(fifo_level),  32'(mq.size()));
        chk({tag, ".coal"},  32'(coalesced),   32'(m_coal));
    endtask

    task automatic step(string tag);
        model_step();
        @(posedge clk); #1;
        model_check(tag);
    endtask

    int got_idx[$];
    int got_val[$];

    task automatic drain(int n, int budget);
        got_idx.delete(); got_val.delete();
        for (int c = 0; c < budget && got_idx.size() < n; c++) begin
            if (ev.ev_valid && ev.ev_ready) begin
                got_idx.push_back(int'(ev.ev_index));
                got_val.push_back(int'(ev.ev_value));
            end
            step("drain");
        end
        chk("drain_count", 32'(got_idx.size()), 32'(n));
    endtask

    typedef struct {
        logic [WIDTH-1:0] ob;
        bit               rdy;
        bit               exp_v;
        int               exp_i;
        bit               exp_val;
        int               exp_l;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TS_W-1:0]  t9, t10;
        logic [WIDTH-1:0] ob;
        logic [IDX_W-1:0] hold_i;
        logic [TS_W-1:0]  hold_t;
        int               n9, seen;

        tbl[0]  = '{32'h0000_0003, 1, 0, 0,  0, 0};
        tbl[1]  = '{32'h0000_0003, 1, 1, 0,  1, 1};
        tbl[2]  = '{32'h0000_0003, 1, 1, 1,  1, 1};
        tbl[3]  = '{32'h0000_0003, 1, 0, 0,  0, 0};
        tbl[4]  = '{32'h0000_0000, 1, 0, 0,  0, 0};
        tbl[5]  = '{32'h0000_0000, 1, 1, 0,  0, 1};
        tbl[6]  = '{32'h0000_0000, 1, 1, 1,  0, 1};
        tbl[7]  = '{32'h0000_0000, 1, 0, 0,  0, 0};
        tbl[8]  = '{32'h8000_0040, 1, 0, 0,  0, 0};
        tbl[9]  = '{32'h8000_0040, 1, 1, 6,  1, 1};
        tbl[10] = '{32'h8000_0040, 1, 1, 31, 1, 1};
        tbl[11] = '{32'h8000_0040, 1, 0, 0,  0, 0};

        // Reset held with out_buf=3 and ready high
        out_buf     = 32'h3;
        ev.ev_ready = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        model_check("reset");
        reset = 1'b1;

        t9 = '0; t10 = '0;
        for (int r = 0; r < 12; r++) begin
            out_buf     = tbl[r].ob;
            ev.ev_ready = tbl[r].rdy;
            step("tbl");
            chk($sformatf("tbl%0d.valid", r), 32'(ev.ev_valid), 32'(tbl[r].exp_v));
            chk($sformatf("tbl%0d.level", r), 32'(fifo_level),  32'(tbl[r].exp_l));
            if (tbl[r].exp_v) begin
                chk($sformatf("tbl%0d.index", r), 32'(ev.ev_index), 32'(tbl[r].exp_i));
                chk($sformatf("tbl%0d.value", r), 32'(ev.ev_value), 32'(tbl[r].exp_val));
            end
            if (r == 9)  t9  = ev.ev_time;
            if (r == 10) t10 = ev.ev_time;
        end
`ifdef OUTPUT_EVENT_TS_EN
        chk("ts_delta", 32'(t10 - t9), 32'd1);
`else
        chk("ts_zero9", 32'(t9), 32'd0);
        chk("ts_zero10", 32'(t10), 32'd0);
`endif

        // Saturate the FIFO with back-pressure, bits 8..11 stay pending
        ev.ev_ready = 1'b0;
        ob = out_buf;
        for (int k = 0; k < 12; k++) begin
            out_buf = out_buf ^ (WIDTH'(1) << k);
            step("fill");
        end
        repeat (3) step("full");
        chk("sat_level", 32'(fifo_level), 32'd8);
        hold_i = ev.ev_index; hold_t = ev.ev_time;
        step("hold");
        chk("hold_index", 32'(ev.ev_index), 32'(hold_i));
        chk("hold_time",  32'(ev.ev_time),  32'(hold_t));
        ev.ev_ready = 1'b1;
        drain(12, 40);
        for (int i = 0; i < got_idx.size(); i++) begin
            chk($sformatf("order%0d.index", i), 32'(got_idx[i]), 32'(i));
            chk($sformatf("order%0d.value", i), 32'(got_val[i]), 32'((ob ^ 32'hFFF) >> i) & 32'd1);
        end
        chk("order_coal", 32'(coalesced), 32'd0);

        // Coalesce: bit 9 toggles twice while stalled behind a full FIFO
        ev.ev_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            out_buf = out_buf ^ (WIDTH'(1) << k);
            step("cfill");
        end
        out_buf = out_buf ^ (WIDTH'(1) << 9);
        step("c9a");
        chk("coal_before", 32'(coalesced), 32'd0);
        out_buf = out_buf ^ (WIDTH'(1) << 9);
        step("c9b");
        chk("coal_set", 32'(coalesced), 32'd1);
        ev.ev_ready = 1'b1;
        drain(10, 40);
        n9 = 0;
        for (int i = 0; i < got_idx.size(); i++) begin
            chk($sformatf("cdrain%0d.index", i), 32'(got_idx[i]), 32'(i));
            if (got_idx[i] == 9) begin
                n9++;
                chk("c9_value", 32'(got_val[i]), 32'(out_buf[9]));
            end
        end
        chk("c9_count", 32'(n9), 32'd1);
        step("idle");
        chk("c_empty", 32'(ev.ev_valid), 32'd0);
        clr_flags = 1'b1;
        step("clr");
        clr_flags = 1'b0;
        chk("coal_clr", 32'(coalesced), 32'd0);

        // Snapshot of every bit
        out_buf  = 32'hA5A5_A5A5;
        snap_req = 1'b1;
        step("snap");
        snap_req = 1'b0;
        drain(32, 80);
        for (int i = 0; i < got_idx.size(); i++) begin
            chk($sformatf("snap%0d.index", i), 32'(got_idx[i]), 32'(i));
            chk($sformatf("snap%0d.value", i), 32'(got_val[i]), 32'((32'hA5A5_A5A5 >> i) & 32'd1));
        end

        // Asynchronous reset with five queued events
        ev.ev_ready = 1'b0;
        snap_req = 1'b1;
        step("rsnap");
        snap_req = 1'b0;
        repeat (5) step("rfill");
        chk("pre_rst_level", 32'(fifo_level), 32'd5);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 32'(ev.ev_valid), 32'd0);
        chk("async_level", 32'(fifo_level), 32'd0);
        model_reset();
        out_buf = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        ev.ev_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step("post_rst");
            if (ev.ev_valid) seen++;
        end
        chk("post_rst_events", 32'(seen), 32'd0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0)  out_buf = out_buf ^ (WIDTH'(1) << $urandom_range(0, 31));
            if ($urandom_range(0, 15) == 0) out_buf = out_buf ^ WIDTH'($urandom);
            snap_req    = ($urandom_range(0, 63) == 0);
            clr_flags   = ($urandom_range(0, 15) == 0);
            ev.ev_ready = ($urandom_range(0, 2) != 0);
            step("rand");
        end
        snap_req  = 1'b0;
        clr_flags = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
